bcd_scan_counter: RTL

- Four-digit BCD counter with a time-multiplexed digit scanner.
- Sits directly upstream of the team's BCD-to-7-segment decoder.
- Drives the decoder's x3..x0 inputs with one digit at a time and drives the active-low digit anodes in step.
- Lets the existing combinational decoder run a 4-digit display that counts 0000..9999.

---
 rtl/bcd_scan_counter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
// Four-digit BCD up-counter (0000..9999) with a time-multiplexed digit
// scanner that feeds a combinational BCD-to-7-segment decoder one digit
// at a time and drives the matching active-low digit anode.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   en         count enable; prescaler and digits hold when low
//   clr        synchronous clear of digits and tick prescaler
//   blank_lz   1 = blank leading-zero digits (ones digit never blanked)
//   x3..x0     selected BCD digit to the decoder (registered)
//   an[3:0]    digit anodes, active-low, an[0] = ones (registered)
//   bcd[15:0]  {thousands, hundreds, tens, ones} digit registers
//   carry_out  one-cycle pulse after the 9999 -> 0000 rollover edge
module bcd_scan_counter #(
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        blank_lz,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic [3:0]  an,
    output logic [15:0] bcd,
    output logic        carry_out
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
    localparam int unsigned NDIG   = 4;

    logic [TICK_W-1:0] r_tick_cnt;
    logic [REF_W-1:0]  r_ref_cnt;
    logic [1:0]        r_idx;
    logic [3:0]        r_digit [NDIG];
    logic              r_carry;
    logic [3:0]        r_an;
    logic [3:0]        r_x;

    logic              w_tick;
    logic              w_ref_wrap;
    logic [NDIG-1:0]   w_is9;
    logic [NDIG-1:0]   w_zero;
    logic [NDIG-1:0]   w_carry_in;
    logic              w_rollover;
    logic [3:0]        w_digit_inc [NDIG];
    logic              w_blank;

    assign w_tick     = en && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_ref_wrap = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));

    // Per-digit flags used by the ripple increment and the blanking logic.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            w_is9[i]  = (r_digit[i] == 4'd9);
            w_zero[i] = (r_digit[i] == 4'd0);
        end
    end

    // A digit receives a carry when every lower digit is 9.
    assign w_carry_in[0] = 1'b1;
    assign w_carry_in[1] = w_is9[0];
    assign w_carry_in[2] = w_is9[0] & w_is9[1];
    assign w_carry_in[3] = w_is9[0] & w_is9[1] & w_is9[2];
    assign w_rollover    = &w_is9;

    // Ripple BCD increment: a carried-into 9 wraps to 0, anything else +1.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            w_digit_inc[i] = r_digit[i];
            if (w_carry_in[i]) begin
                w_digit_inc[i] = w_is9[i] ? 4'd0 : (r_digit[i] + 4'd1);
            end
        end
    end

    // Slot is blank when it and every higher digit are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = w_zero[3] & w_zero[2] & w_zero[1];
            2'd2:    w_blank = w_zero[3] & w_zero[2];
            2'd3:    w_blank = w_zero[3];
            default: w_blank = 1'b0;
        endcase
        w_blank = w_blank & blank_lz;
    end

    // Tick prescaler, digit registers and rollover pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            for (int i = 0; i < NDIG; i++) r_digit[i] <= 4'd0;
            r_carry    <= 1'b0;
        end else if (clr) begin
            r_tick_cnt <= '0;
            for (int i = 0; i < NDIG; i++) r_digit[i] <= 4'd0;
            r_carry    <= 1'b0;
        end else begin
            r_carry <= w_tick && w_rollover;
            if (en) begin
                r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + TICK_W'(1));
            end
            if (w_tick) begin
                for (int i = 0; i < NDIG; i++) r_digit[i] <= w_digit_inc[i];
            end
        end
    end

    // Free-running refresh counter and scan index; ignores en and clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (w_ref_wrap) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
        end
    end

    // Registered scan outputs from the pre-edge index and digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an <= 4'b1110;
            r_x  <= 4'd0;
        end else if (w_blank) begin
            r_an <= 4'b1111;
            r_x  <= 4'd0;
        end else begin
            r_an <= ~(4'b0001 << r_idx);
            r_x  <= r_digit[r_idx];
        end
    end

    assign an        = r_an;
    assign {x3, x2, x1, x0} = r_x;
    assign bcd       = {r_digit[3], r_digit[2], r_digit[1], r_digit[0]};
    assign carry_out = r_carry;

endmodule
